rca_pipe_adder: RTL and testbench
=================================

// Module: rca_pipe_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry add/subtract unit; successor to the 4-bit combinational RCA.
//   WIDTH-bit operands are split into STAGES equal slices. Each slice is a generate-built
//   full-adder chain, and the carry is registered between slices.
//   Valid/ready handshakes on input and output; sits between operand sources and the accumulator/ALU datapath.
// PARAMETERS
//   WIDTH   16  operand/sum width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline stages = latency in cycles; 1..WIDTH; SLICE = WIDTH/STAGES bits per stage
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit accepts beat this cycle
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      0: a+b+cin   1: a-b (a + ~b + 1, cin ignored)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result bits
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - All stage valid bits clear; all data/carry registers clear.
//     - sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 once reset is released.
//   Transfers:
//     - Input transfer occurs on in_valid & in_ready.
//     - Output transfer occurs on out_valid & out_ready.
//   Stall:
//     - adv = ~out_valid | out_ready.
//     - in_ready = adv (combinational).
//     - All stages shift only when adv=1; otherwise every stage register holds.
//     - No bubble compression, so pipeline order equals input order.
//   Stage k (0..STAGES-1), on adv:
//     - Adds slice k of a and b_eff with the registered carry from stage k-1.
//       Stage 0 uses cin_eff, where b_eff = sub ? ~b : b and cin_eff = sub ? 1 : cin.
//     - Registers the resulting SLICE sum bits and the slice carry-out.
//     - Forwards already-computed lower sum bits and not-yet-used upper operand slices, skewed one stage.
//     - Stage k valid <= valid of stage k-1 (stage 0 <= in_valid).
//   Latency:
//     - Exactly STAGES cycles from input transfer to out_valid when out_ready=1.
//     - Throughput is 1 result per cycle.
//   cout/ovf:
//     - Taken from the final stage.
//     - ovf needs the carry into the MSB, which is captured in the last stage alongside its carry-out.
//   Width rules:
//     - sum wraps modulo 2^WIDTH.
//     - Sub mode with a<b gives the two's-complement result and cout=0.
//   Bubbles: in_valid=0 while adv=1 inserts an invalid slot; data in invalid slots is don't-care and must not raise out_valid.
//   Backpressure: out_ready=0 with out_valid=1 freezes the pipe; sum/cout/ovf stay stable until accepted.
//   Simultaneous events: in the same cycle, the pipe accepts a new beat and retires the head when out_ready=1.
//   Reset mid-operation: all in-flight beats are discarded, with no partial result emitted after release.
//   STAGES=1: degenerates to a single registered full-width adder with latency 1.
// TESTING
//   T1 WIDTH=4,STAGES=1: a=1,b=2,cin=0,sub=0 -> one cycle later sum=3,cout=0,ovf=0.
//   T2 WIDTH=4,STAGES=2: a=4,b=3,cin=1 then a=2,b=4,cin=1 back-to-back -> sum=8 (ovf=1), then sum=7, on consecutive cycles 2 and 3.
//   T3 defaults: a=16'hFFFF,b=16'h0001,cin=0 -> after 4 cycles sum=0,cout=1,ovf=0; a=16'h7FFF,b=1 -> sum=16'h8000,ovf=1.
//   T4 defaults, sub=1: a=5,b=7 -> sum=16'hFFFE,cout=0,ovf=0; a=16'h8000,b=1 -> sum=16'h7FFF,ovf=1; cin toggling has no effect.
//   T5 defaults: stream 10 random beats with out_ready held low for 3 cycles mid-stream -> in_ready=0 and outputs stable during the stall; all 10 results in order, none lost or duplicated.
//   T6 defaults: 3 beats in flight, pulse rst_n low for half a cycle -> out_valid=0 and sum=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/rca_pipe_adder.sv
// rca_pipe_adder: pipelined ripple-carry add/subtract unit. Each stage adds one SLICE-bit
// slice with a full-adder chain; carries, partial sums and unused operand slices move stage to stage.
module rca_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  logic             adv_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;

  assign adv_s     = ~out_valid | out_ready;
  assign in_ready  = adv_s;
  assign b_eff_s   = sub ? ~b : b;
  assign cin_eff_s = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int BW = WIDTH - k * SLICE;

    logic [WIDTH-1:0] a_in_s;
    logic [BW-1:0]    b_in_s;
    logic             ci_s;
    logic             vin_s;
    logic [SLICE-1:0] ss_s;
    logic [SLICE:0]   c_s;
    logic [WIDTH-1:0] a_nxt_s;
    logic             valid_r;
    logic             c_r;
    // Holds finished sum slices at the top and still-unused A slices at the bottom.
    logic [WIDTH-1:0] a_r;

    if (k == 0) begin : g_src
      assign a_in_s = a;
      assign b_in_s = b_eff_s;
      assign ci_s   = cin_eff_s;
      assign vin_s  = in_valid;
    end else begin : g_src
      assign a_in_s = g_stg[k-1].a_r;
      assign b_in_s = g_stg[k-1].g_b.b_r;
      assign ci_s   = g_stg[k-1].c_r;
      assign vin_s  = g_stg[k-1].valid_r;
    end

    // Ripple the slice through a chain of full adders.
    always_comb begin
      c_s    = {(SLICE+1){1'b0}};
      ss_s   = {SLICE{1'b0}};
      c_s[0] = ci_s;
      for (int j = 0; j < SLICE; j++) begin
        {c_s[j+1], ss_s[j]} = fa(a_in_s[j], b_in_s[j], c_s[j]);
      end
    end

    if (SLICE == WIDTH) begin : g_rot
      assign a_nxt_s = ss_s;
    end else begin : g_rot
      assign a_nxt_s = {ss_s, a_in_s[WIDTH-1:SLICE]};
    end

    // Stage valid, carry and rotating sum/operand word; frozen while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        c_r     <= 1'b0;
        a_r     <= {WIDTH{1'b0}};
      end else if (adv_s) begin
        valid_r <= vin_s;
        c_r     <= c_s[SLICE];
        a_r     <= a_nxt_s;
      end
    end

    if (k < STAGES - 1) begin : g_b
      logic [BW-SLICE-1:0] b_r;
      // Upper B slices not yet consumed by this stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_r <= {(BW-SLICE){1'b0}};
        end else if (adv_s) begin
          b_r <= b_in_s[BW-1:SLICE];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_r;
      // Signed overflow from carry into and out of the MSB of the final slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= c_s[SLICE] ^ c_s[SLICE-1];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].valid_r;
  assign sum       = g_stg[STAGES-1].a_r;
  assign cout      = g_stg[STAGES-1].c_r;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Scoreboard bench for rca_pipe_adder: a 16-bit/4-stage instance plus 4-bit instances with
// one and two stages, all checked against hand-computed expected results.
module tb_rca_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-bit instances share their inputs
  logic       s_in_valid, s_cin, s_sub;
  logic [3:0] s_a, s_b;
  logic       s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
  logic [3:0] s1_sum;
  logic       s2_in_ready, s2_out_valid, s2_cout, s2_ovf;
  logic [3:0] s2_sum;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  typedef struct { logic [3:0] sum; logic cout; logic ovf; int unsigned cyc; } exp4_t;
  typedef struct { logic [15:0] sum; logic cout; logic ovf; } exp16_t;
  exp4_t  q1[$];
  exp4_t  q2[$];
  exp16_t q16[$];

  typedef struct packed {
    logic [15:0] a; logic [15:0] b; logic c; logic s; logic [15:0] e; logic co; logic ov;
  } vec_t;
  vec_t t5 [10] = '{
    '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0},
    '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0},
    '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0},
    '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1},
    '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0}
  };

  rca_pipe_adder #(.WIDTH(4), .STAGES(1)) u_w4s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s1_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s1_out_valid),
    .out_ready(1'b1), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf));

  rca_pipe_adder #(.WIDTH(4), .STAGES(2)) u_w4s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s2_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s2_out_valid),
    .out_ready(1'b1), .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf));

  rca_pipe_adder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon16
    exp16_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL m16_unexpected: got sum %h, expected no output", sum);
      end else begin
        e = q16.pop_front();
        check("m16_sum", 32'(sum), 32'(e.sum));
        check("m16_flags", 32'({cout, ovf}), 32'({e.cout, e.ovf}));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp4_t e;
    if (rst_n && s1_out_valid) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL m1_unexpected: got sum %h, expected no output", s1_sum);
      end else begin
        e = q1.pop_front();
        check("m1_sum", 32'(s1_sum), 32'(e.sum));
        check("m1_flags", 32'({s1_cout, s1_ovf}), 32'({e.cout, e.ovf}));
        check("m1_latency", cyc - e.cyc, 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp4_t e;
    if (rst_n && s2_out_valid) begin
      if (q2.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL m2_unexpected: got sum %h, expected no output", s2_sum);
      end else begin
        e = q2.pop_front();
        check("m2_sum", 32'(s2_sum), 32'(e.sum));
        check("m2_flags", 32'({s2_cout, s2_ovf}), 32'({e.cout, e.ovf}));
        check("m2_latency", cyc - e.cyc, 32'd2);
      end
    end
  end

  task automatic send4(input logic [3:0] av, input logic [3:0] bv, input logic c, input logic s,
                       input logic [3:0] es, input logic ec, input logic eo);
    s_a = av; s_b = bv; s_cin = c; s_sub = s; s_in_valid = 1'b1;
    @(negedge clk);
    check("s1_in_ready", 32'(s1_in_ready), 32'd1);
    check("s2_in_ready", 32'(s2_in_ready), 32'd1);
    q1.push_back('{es, ec, eo, cyc});
    q2.push_back('{es, ec, eo, cyc});
    @(posedge clk); #1;
  endtask

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
    int guard = 0;
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send16_timeout: in_ready 0, expected 1");
    end else begin
      q16.push_back('{es, ec, eo});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_a = 4'h0; s_b = 4'h0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", 32'({cout, ovf}), 32'd0);
    check("rst_s1_out_valid", 32'(s1_out_valid), 32'd0);
    check("rst_s2_out_valid", 32'(s2_out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // T1/T2 on both 4-bit instances, back-to-back
    send4(4'h1, 4'h2, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    send4(4'h4, 4'h3, 1'b1, 1'b0, 4'h8, 1'b0, 1'b1);
    send4(4'h2, 4'h4, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    send4(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
    send4(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    s_in_valid = 1'b0;

    // T3 carry/overflow edges, T4 subtract with cin ignored
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T5 stream with a 3-cycle output stall after beat 4
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t5_in_ready", 32'(in_ready), 32'd0);
          check("t5_out_valid", 32'(out_valid), 32'd1);
          if (q16.size() > 0) begin
            check("t5_hold_sum", 32'(sum), 32'(q16[0].sum));
            check("t5_hold_flags", 32'({cout, ovf}), 32'({q16[0].cout, q16[0].ovf}));
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      send16(t5[i].a, t5[i].b, t5[i].c, t5[i].s, t5[i].e, t5[i].co, t5[i].ov);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 50; i++) begin
      if (q16.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_q16", 32'(q16.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);

    // T6 reset with beats in flight
    out_ready = 1'b0;
    send16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    send16(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
    send16(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_head_valid", 32'(out_valid), 32'd1);
    check("t6_head_sum", 32'(sum), 32'h0002);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum", 32'(sum), 32'd0);
    check("t6_rst_flags", 32'({cout, ovf}), 32'd0);
    q16.delete();
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("t6_no_stale", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
